// File: rtl/adc_packetizer_pkg.sv
// Shared types for the ADC packetizer: FSM states, FIFO entry layout and CTRL register bit positions.
package digitizer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DONE
    } state_e;

    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } fifo_word_t;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_CONT_BIT   = 1;

    // Packet sizes are programmed in bytes; the datapath counts 32-bit words.
    function automatic logic [29:0] bytes_to_words(input logic [31:0] bytes);
        return bytes[31:2];
    endfunction

endpackage

// File: rtl/adc_packetizer_sync_fifo.sv
// Single-clock FIFO with full/empty flags; the head entry is presented from the storage flops.
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_write;
    logic             do_read;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    // A pop in the same cycle frees a slot, so a write on a full FIFO still lands.
    always_comb begin
        do_read  = rd_en & ~empty;
        do_write = wr_en & (~full | do_read);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_write) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_read) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_write, do_read})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/adc_packetizer.sv
// Packs pairs of 16-bit ADC samples into 32-bit AXI4-Stream words grouped into tlast-terminated packets.
// Define ADC_TEST_PATTERN_EN to replace adc_data with an internal ramp counter.
module adc_packetizer
    import digitizer_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [15:0]      adc_data,
    input  logic             adc_valid,
    input  logic             cfg_enable,
    input  logic             cfg_continuous,
    input  logic [31:0]      cfg_packet_size,
    output logic [31:0]      m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic             sts_busy,
    output logic             sts_overflow,
    output logic [CNT_W-1:0] sts_packet_count
);

    state_e           state_q, state_d;
    logic [29:0]      words_q, words_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic             half_q, half_d;
    logic [15:0]      low_q, low_d;
    logic             enable_q;
    logic             overflow_q, overflow_d;

    logic             enable_rise;
    logic [29:0]      new_words;
    logic             last_word;
    logic [15:0]      sample;
    logic             push;
    fifo_word_t       push_word;
    fifo_word_t       head_word;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_rd_en;
    logic             unused_size_bits;

    assign unused_size_bits = ^cfg_packet_size[1:0];
    assign enable_rise      = cfg_enable & ~enable_q;
    assign new_words        = bytes_to_words(cfg_packet_size);
    assign last_word        = (word_cnt_q == (CNT_W'(words_q) - CNT_W'(1)));

`ifdef ADC_TEST_PATTERN_EN
    logic [15:0] pattern_q, pattern_d;
    logic        unused_adc_data;

    assign unused_adc_data = ^adc_data;
    assign sample          = pattern_q;

    always_comb begin
        pattern_d = pattern_q;
        if (enable_rise) begin
            pattern_d = '0;
        end else if (adc_valid) begin
            pattern_d = pattern_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pattern_q <= '0;
        end else begin
            pattern_q <= pattern_d;
        end
    end
`else
    assign sample = adc_data;
`endif

    // Packets always run to full length once started; enable only decides whether another follows.
    always_comb begin
        state_d    = state_q;
        words_d    = words_q;
        word_cnt_d = word_cnt_q;
        pkt_cnt_d  = pkt_cnt_q;
        half_d     = half_q;
        low_d      = low_q;
        overflow_d = overflow_q;
        push       = 1'b0;
        push_word  = '0;

        if (enable_rise) begin
            overflow_d = 1'b0;
            pkt_cnt_d  = '0;
        end

        case (state_q)
            IDLE: begin
                if (enable_rise && new_words != '0) begin
                    state_d    = CAPTURE;
                    words_d    = new_words;
                    word_cnt_d = '0;
                    half_d     = 1'b0;
                end
            end
            CAPTURE: begin
                if (adc_valid) begin
                    if (!half_q) begin
                        low_d  = sample;
                        half_d = 1'b1;
                    end else begin
                        push           = 1'b1;
                        push_word.data = {sample, low_q};
                        push_word.last = last_word;
                        half_d         = 1'b0;
                        word_cnt_d     = word_cnt_q + CNT_W'(1);
                        if (last_word) begin
                            pkt_cnt_d  = pkt_cnt_d + CNT_W'(1);
                            word_cnt_d = '0;
                            if (cfg_continuous && cfg_enable && new_words != '0) begin
                                words_d = new_words;
                            end else begin
                                state_d = DONE;
                            end
                        end
                    end
                end
            end
            DONE: begin
                if (!cfg_enable) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A dropped word still advances the counter so packet boundaries stay aligned.
        if (push && fifo_full && !fifo_rd_en) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            words_q    <= '0;
            word_cnt_q <= '0;
            pkt_cnt_q  <= '0;
            half_q     <= 1'b0;
            low_q      <= '0;
            enable_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            words_q    <= words_d;
            word_cnt_q <= word_cnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
            half_q     <= half_d;
            low_q      <= low_d;
            enable_q   <= cfg_enable;
            overflow_q <= overflow_d;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(fifo_word_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .wr_en   (push),
        .wr_data (push_word),
        .rd_en   (fifo_rd_en),
        .rd_data (head_word),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign m_axis_tvalid    = ~fifo_empty;
    assign fifo_rd_en       = m_axis_tvalid & m_axis_tready;
    assign m_axis_tdata     = head_word.data;
    assign m_axis_tlast     = head_word.last;
    assign sts_busy         = (state_q != IDLE) | ~fifo_empty;
    assign sts_overflow     = overflow_q;
    assign sts_packet_count = pkt_cnt_q;

endmodule

// File: tb/tb_adc_packetizer.sv
// Directed bench for adc_packetizer: a scoreboard queue holds the words each sample pair should produce.
module tb_adc_packetizer;

    logic        clk;
    logic        resetn;
    logic [15:0] adc_data;
    logic        adc_valid;
    logic        cfg_enable;
    logic        cfg_continuous;
    logic [31:0] cfg_packet_size;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        sts_busy;
    logic        sts_overflow;
    logic [31:0] sts_packet_count;

    int          compared;
    int          mismatched;
    logic [32:0] sb[$];

    logic [15:0] ramp;
    logic [15:0] low_sample;
    bit          have_low;
    int          pkt_words;
    int          word_idx;

    adc_packetizer #(
        .FIFO_DEPTH (16),
        .CNT_W      (32)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
        .adc_data         (adc_data),
        .adc_valid        (adc_valid),
        .cfg_enable       (cfg_enable),
        .cfg_continuous   (cfg_continuous),
        .cfg_packet_size  (cfg_packet_size),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .m_axis_tlast     (m_axis_tlast),
        .sts_busy         (sts_busy),
        .sts_overflow     (sts_overflow),
        .sts_packet_count (sts_packet_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one valid sample of the ramp; on every second sample the expected word is queued.
    task automatic applyStimulus(input bit keep);
        logic [32:0] exp_w;
        bit          is_last;
        adc_data  = ramp;
        adc_valid = 1'b1;
        if (have_low) begin
            is_last = (word_idx == pkt_words - 1);
            exp_w   = {is_last, ramp, low_sample};
            if (keep) sb.push_back(exp_w);
            word_idx = is_last ? 0 : word_idx + 1;
            have_low = 1'b0;
        end else begin
            low_sample = ramp;
            have_low   = 1'b1;
        end
        ramp = ramp + 16'd1;
        step();
        adc_valid = 1'b0;
    endtask

    task automatic armPacket(input logic [31:0] size, input logic cont);
        cfg_packet_size = size;
        cfg_continuous  = cont;
        cfg_enable      = 1'b1;
        step();
        ramp      = '0;
        have_low  = 1'b0;
        word_idx  = 0;
        pkt_words = int'(size >> 2);
    endtask

    task automatic waitDrain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sb.size() == 0) break;
            step();
        end
        checkOutput("drain_done", 64'(sb.size()), 64'd0);
    endtask

    // Every accepted beat is matched against the head of the scoreboard.
    always @(negedge clk) begin
        if (resetn && m_axis_tvalid && m_axis_tready) begin
            logic [32:0] exp_w;
            compared++;
            assert (sb.size() != 0) else begin
                mismatched++;
                $error("[TB] FAIL unexpected_beat: observed tdata 0x%0h with empty scoreboard, expected no beat", m_axis_tdata);
            end
            if (sb.size() != 0) begin
                exp_w = sb.pop_front();
                checkOutput("tdata", 64'(m_axis_tdata), 64'(exp_w[31:0]));
                checkOutput("tlast", 64'(m_axis_tlast), 64'(exp_w[32]));
            end
        end
    end

    initial begin
        compared        = 0;
        mismatched      = 0;
        resetn          = 1'b0;
        adc_data        = '0;
        adc_valid       = 1'b0;
        cfg_enable      = 1'b0;
        cfg_continuous  = 1'b0;
        cfg_packet_size = '0;
        m_axis_tready   = 1'b1;
        ramp            = '0;
        low_sample      = '0;
        have_low        = 1'b0;
        pkt_words       = 0;
        word_idx        = 0;

        repeat (3) step();
        checkOutput("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        checkOutput("rst_tlast", 64'(m_axis_tlast), 64'd0);
        checkOutput("rst_tdata", 64'(m_axis_tdata), 64'd0);
        checkOutput("rst_busy", 64'(sts_busy), 64'd0);
        checkOutput("rst_overflow", 64'(sts_overflow), 64'd0);
        checkOutput("rst_count", 64'(sts_packet_count), 64'd0);
        resetn = 1'b1;
        step();

        $display("[TB] single 4-word packet");
        armPacket(32'd16, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1);
        waitDrain(50);
        checkOutput("t1_count", 64'(sts_packet_count), 64'd1);
        cfg_enable = 1'b0;
        repeat (2) step();
        checkOutput("t1_busy", 64'(sts_busy), 64'd0);

        $display("[TB] continuous back-to-back packets");
        armPacket(32'd32, 1'b1);
        for (int i = 0; i < 16; i++) applyStimulus(1'b1);
        checkOutput("t2_count1", 64'(sts_packet_count), 64'd1);
        for (int i = 0; i < 16; i++) applyStimulus(1'b1);
        checkOutput("t2_count2", 64'(sts_packet_count), 64'd2);
        cfg_enable = 1'b0;
        for (int i = 0; i < 16; i++) applyStimulus(1'b1);
        waitDrain(50);
        checkOutput("t2_count3", 64'(sts_packet_count), 64'd3);
        repeat (2) step();
        checkOutput("t2_busy", 64'(sts_busy), 64'd0);

        $display("[TB] overflow with stalled stream");
        m_axis_tready = 1'b0;
        armPacket(32'd64, 1'b1);
        for (int i = 0; i < 40; i++) applyStimulus(i < 32);
        checkOutput("t3_overflow", 64'(sts_overflow), 64'd1);
        checkOutput("t3_count", 64'(sts_packet_count), 64'd1);
        checkOutput("t3_tvalid", 64'(m_axis_tvalid), 64'd1);
        checkOutput("t3_head", 64'(m_axis_tdata), 64'h0001_0000);
        cfg_enable    = 1'b0;
        m_axis_tready = 1'b1;
        waitDrain(50);
        for (int i = 0; i < 24; i++) applyStimulus(1'b1);
        waitDrain(50);
        checkOutput("t3_count2", 64'(sts_packet_count), 64'd2);
        checkOutput("t3_sticky", 64'(sts_overflow), 64'd1);
        repeat (2) step();
        checkOutput("t3_busy", 64'(sts_busy), 64'd0);

        $display("[TB] enable dropped mid-packet");
        armPacket(32'd32, 1'b0);
        checkOutput("t4_ovf_clear", 64'(sts_overflow), 64'd0);
        checkOutput("t4_cnt_clear", 64'(sts_packet_count), 64'd0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1);
        cfg_enable = 1'b0;
        for (int i = 0; i < 12; i++) applyStimulus(1'b1);
        waitDrain(50);
        repeat (2) step();
        checkOutput("t4_busy", 64'(sts_busy), 64'd0);
        checkOutput("t4_count", 64'(sts_packet_count), 64'd1);

        $display("[TB] zero-word packet sizes");
        armPacket(32'd0, 1'b0);
        adc_valid = 1'b1;
        repeat (4) step();
        adc_valid = 1'b0;
        checkOutput("t5_busy0", 64'(sts_busy), 64'd0);
        checkOutput("t5_tvalid0", 64'(m_axis_tvalid), 64'd0);
        cfg_enable = 1'b0;
        step();
        armPacket(32'd3, 1'b0);
        adc_valid = 1'b1;
        repeat (4) step();
        adc_valid = 1'b0;
        checkOutput("t5_busy3", 64'(sts_busy), 64'd0);
        checkOutput("t5_tvalid3", 64'(m_axis_tvalid), 64'd0);
        cfg_enable = 1'b0;
        step();

        $display("[TB] reset mid-packet");
        m_axis_tready = 1'b0;
        armPacket(32'd16, 1'b0);
        for (int i = 0; i < 7; i++) applyStimulus(1'b0);
        checkOutput("t6_pre_tvalid", 64'(m_axis_tvalid), 64'd1);
        resetn     = 1'b0;
        cfg_enable = 1'b0;
        step();
        checkOutput("t6_tvalid", 64'(m_axis_tvalid), 64'd0);
        checkOutput("t6_busy", 64'(sts_busy), 64'd0);
        resetn        = 1'b1;
        m_axis_tready = 1'b1;
        step();
        armPacket(32'd16, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1);
        waitDrain(50);
        checkOutput("t6_count", 64'(sts_packet_count), 64'd1);
        cfg_enable = 1'b0;
        repeat (3) step();
        checkOutput("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
